ram8_bank: RTL and testbench
============================

RAM8_BANK -- requirements
Module: ram8_bank

Interface
REQ-001: Parameter WIDTH, default 16, SHALL set the data word width in bits.
REQ-002: CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003: RST  input  1  SHALL be the reset; it SHALL be synchronous and active-high.
REQ-004: IN  input  WIDTH  SHALL be the write data.
REQ-005: LOAD  input  1  SHALL be the write strobe, sampled at the rising edge of CLK.
REQ-006: ADDRESS  input  3  SHALL select one of 8 words for both read and write.
REQ-007: OUT  output  WIDTH  SHALL be the contents of the word selected by ADDRESS.
REQ-008: VALID  output  1  SHALL indicate that the word selected by ADDRESS has been written since the last reset.
REQ-009: VALID_MASK  output  8  SHALL expose the per-word written flags, bit n for word n.

Function
REQ-010: Storage SHALL be eight registers of WIDTH bits each, word0..word7, plus an 8-bit written-flag register.
REQ-011: LOAD SHALL be routed to exactly one word by a 1-to-8 demultiplex on ADDRESS (DMUX8WAY stage); non-selected words SHALL receive load = 0.
REQ-012: On a rising edge with RST = 0 and LOAD = 1, word[ADDRESS] SHALL take IN and VALID_MASK[ADDRESS] SHALL be set to 1.
REQ-013: On a rising edge with RST = 0 and LOAD = 0, all words and VALID_MASK SHALL hold their values.
REQ-014: Words other than word[ADDRESS] SHALL never change on a non-reset edge.
REQ-015: OUT and VALID SHALL be combinational functions of ADDRESS and stored state, with zero-cycle read latency.
REQ-016: Write latency SHALL be one cycle; data written at edge k SHALL be visible on OUT from just after edge k.
REQ-017: In a cycle with LOAD = 1, OUT SHALL show the pre-write contents of word[ADDRESS] until the edge (read-before-write).
REQ-018: Rewriting an already-valid word SHALL overwrite its data and leave its VALID_MASK bit at 1.
REQ-019: ADDRESS changes between edges SHALL only change OUT/VALID, never stored state.
REQ-020: All eight ADDRESS values 0..7 SHALL be legal; no wrap-around or out-of-range case exists.

Reset
REQ-021: On a rising edge with RST = 1, all eight words SHALL become 0 and VALID_MASK SHALL become 8'b00000000.
REQ-022: RST SHALL take priority over LOAD; a write requested on a reset edge SHALL be discarded.
REQ-023: After reset, OUT SHALL read 0 and VALID SHALL read 0 for every ADDRESS.
REQ-024: Before the first reset edge, stored contents are undefined; the bench SHALL apply reset first.
REQ-025: RST deasserted mid-sequence SHALL cause no partial or delayed write; the first edge with RST = 0 SHALL behave per REQ-012/REQ-013.

Verification
REQ-026: Reset, then sweep ADDRESS 0..7 with LOAD = 0 -> OUT = 0, VALID = 0, VALID_MASK = 8'h00 at every address.
REQ-027: Write IN = 16'h1000 + n to each address n = 0..7 (one per edge), then read back 0..7 -> OUT = 16'h1000 + n, VALID = 1, final VALID_MASK = 8'hFF.
REQ-028: Reset; ADDRESS = 3, IN = 16'hBEEF, LOAD = 1 for one edge -> before the edge OUT = 0; after the edge OUT = 16'hBEEF, VALID_MASK = 8'b00001000, all other words read 0.
REQ-029: Reset; LOAD = 1 with RST = 1, ADDRESS = 5, IN = 16'hFFFF -> after the edge word5 = 0, VALID_MASK = 8'h00.
REQ-030: Write 16'hAAAA to address 6, then 16'h5555 to address 6 -> OUT = 16'h5555, VALID_MASK bit 6 = 1, word7 unchanged at 0.
REQ-031: LOAD = 0, IN toggled randomly over 8 edges while ADDRESS sweeps 0..7 -> all words and VALID_MASK unchanged.

Source files
------------

// File: rtl/ram8_bank.sv
// ram8_bank: eight-word register bank with per-word written flags.
//
// Ports:
//   CLK        - single clock, all state updates on its rising edge
//   RST        - synchronous active-high reset; clears all words and flags
//   IN         - write data, WIDTH bits
//   LOAD       - write strobe, sampled at the rising edge of CLK
//   ADDRESS    - 3-bit word select, shared by read and write
//   OUT        - contents of word[ADDRESS], combinational (zero-cycle read)
//   VALID      - word[ADDRESS] has been written since the last reset
//   VALID_MASK - per-word written flags, bit n for word n
//
// Reads return the stored value, so during a write cycle OUT shows the
// pre-write contents until the edge (read-before-write).
module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             LOAD,
    input  logic [2:0]       ADDRESS,
    output logic [WIDTH-1:0] OUT,
    output logic             VALID,
    output logic [7:0]       VALID_MASK
);

    logic [WIDTH-1:0] word_r [8];
    logic [7:0]       valid_r;
    logic [7:0]       load_s;
    logic [WIDTH-1:0] read_data_s;
    logic             read_valid_s;

    // Demultiplex the write strobe so exactly one word sees LOAD.
    always_comb begin
        load_s = 8'b0000_0000;
        if (LOAD) begin
            case (ADDRESS)
                3'd0:    load_s = 8'b0000_0001;
                3'd1:    load_s = 8'b0000_0010;
                3'd2:    load_s = 8'b0000_0100;
                3'd3:    load_s = 8'b0000_1000;
                3'd4:    load_s = 8'b0001_0000;
                3'd5:    load_s = 8'b0010_0000;
                3'd6:    load_s = 8'b0100_0000;
                3'd7:    load_s = 8'b1000_0000;
                default: load_s = 8'b0000_0000;
            endcase
        end else begin
            load_s = 8'b0000_0000;
        end
    end

    // Word storage and written flags; reset wins over a concurrent write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                word_r[i] <= {WIDTH{1'b0}};
            end
            valid_r <= 8'b0000_0000;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load_s[i]) begin
                    word_r[i]  <= IN;
                    valid_r[i] <= 1'b1;
                end
            end
        end
    end

    // Combinational read mux for data and its written flag.
    always_comb begin
        read_data_s  = {WIDTH{1'b0}};
        read_valid_s = 1'b0;
        case (ADDRESS)
            3'd0:    begin read_data_s = word_r[0]; read_valid_s = valid_r[0]; end
            3'd1:    begin read_data_s = word_r[1]; read_valid_s = valid_r[1]; end
            3'd2:    begin read_data_s = word_r[2]; read_valid_s = valid_r[2]; end
            3'd3:    begin read_data_s = word_r[3]; read_valid_s = valid_r[3]; end
            3'd4:    begin read_data_s = word_r[4]; read_valid_s = valid_r[4]; end
            3'd5:    begin read_data_s = word_r[5]; read_valid_s = valid_r[5]; end
            3'd6:    begin read_data_s = word_r[6]; read_valid_s = valid_r[6]; end
            3'd7:    begin read_data_s = word_r[7]; read_valid_s = valid_r[7]; end
            default: begin read_data_s = {WIDTH{1'b0}}; read_valid_s = 1'b0; end
        endcase
    end

    assign OUT        = read_data_s;
    assign VALID      = read_valid_s;
    assign VALID_MASK = valid_r;

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: directed self-checking bench for ram8_bank (WIDTH = 16).
// Inputs change 1 time unit after each rising edge; outputs are checked
// while inputs are stable, before the next rising edge.
module tb_ram8_bank;

    logic        clk_s;
    logic        rst_s;
    logic [15:0] in_s;
    logic        load_s;
    logic [2:0]  address_s;
    logic [15:0] out_s;
    logic        valid_s;
    logic [7:0]  valid_mask_s;

    int checks_r;
    int errors_r;

    ram8_bank #(.WIDTH(16)) dut (
        .CLK        (clk_s),
        .RST        (rst_s),
        .IN         (in_s),
        .LOAD       (load_s),
        .ADDRESS    (address_s),
        .OUT        (out_s),
        .VALID      (valid_s),
        .VALID_MASK (valid_mask_s)
    );

    // 10-unit clock.
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    // Single comparison point: count, and report any mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic do_reset();
        rst_s  = 1'b1;
        load_s = 1'b0;
        step();
        rst_s  = 1'b0;
    endtask

    // Read every address with LOAD low and compare against expected tables.
    task automatic sweep(input string tag, input logic [15:0] exp_word [8], input logic [7:0] exp_mask);
        load_s = 1'b0;
        for (int a = 0; a < 8; a++) begin
            address_s = a[2:0];
            #1;
            check($sformatf("%s_out%0d", tag, a), {16'h0000, out_s}, {16'h0000, exp_word[a]});
            check($sformatf("%s_valid%0d", tag, a), {31'd0, valid_s}, {31'd0, exp_mask[a]});
        end
        check($sformatf("%s_mask", tag), {24'd0, valid_mask_s}, {24'd0, exp_mask});
    endtask

    logic [15:0] zero_words [8];
    logic [15:0] exp_words  [8];

    initial begin
        checks_r  = 0;
        errors_r  = 0;
        rst_s     = 1'b1;
        load_s    = 1'b0;
        in_s      = 16'h0000;
        address_s = 3'd0;
        for (int i = 0; i < 8; i++) zero_words[i] = 16'h0000;

        // Reset state at every address.
        do_reset();
        sweep("rst", zero_words, 8'h00);

        // Fill all words, checking read-before-write on each write cycle.
        for (int n = 0; n < 8; n++) begin
            address_s = n[2:0];
            in_s      = 16'h1000 + n[15:0];
            load_s    = 1'b1;
            #1;
            check($sformatf("fill_pre%0d", n), {16'h0000, out_s}, 32'h0000_0000);
            step();
        end
        load_s = 1'b0;
        for (int n = 0; n < 8; n++) exp_words[n] = 16'h1000 + n[15:0];
        sweep("fill", exp_words, 8'hFF);

        // Single write to address 3.
        do_reset();
        address_s = 3'd3;
        in_s      = 16'hBEEF;
        load_s    = 1'b1;
        #1;
        check("beef_pre", {16'h0000, out_s}, 32'h0000_0000);
        step();
        load_s = 1'b0;
        exp_words = zero_words;
        exp_words[3] = 16'hBEEF;
        sweep("beef", exp_words, 8'b0000_1000);

        // Reset discards a concurrent write; next clean edge writes nothing.
        rst_s     = 1'b1;
        load_s    = 1'b1;
        address_s = 3'd5;
        in_s      = 16'hFFFF;
        step();
        rst_s  = 1'b0;
        load_s = 1'b0;
        #1;
        check("rstpri_out", {16'h0000, out_s}, 32'h0000_0000);
        check("rstpri_mask", {24'd0, valid_mask_s}, 32'h0000_0000);
        step();
        check("rstpri_after", {24'd0, valid_mask_s}, 32'h0000_0000);

        // Overwrite address 6.
        address_s = 3'd6;
        in_s      = 16'hAAAA;
        load_s    = 1'b1;
        step();
        check("ow_first", {16'h0000, out_s}, 32'h0000_AAAA);
        in_s = 16'h5555;
        step();
        load_s = 1'b0;
        check("ow_second", {16'h0000, out_s}, 32'h0000_5555);
        check("ow_valid", {31'd0, valid_s}, 32'd1);
        exp_words = zero_words;
        exp_words[6] = 16'h5555;
        sweep("ow", exp_words, 8'b0100_0000);

        // LOAD low with random IN while sweeping address: nothing changes.
        for (int k = 0; k < 8; k++) begin
            address_s = k[2:0];
            in_s      = 16'($urandom);
            load_s    = 1'b0;
            step();
        end
        sweep("hold", exp_words, 8'b0100_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
